// File: rtl/iir_pkg.sv
// Shared types and constants for the time-multiplexed first-order IIR scheduler.
package iir_pkg;

  localparam int W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MB0,
    S_MB1,
    S_MA1,
    S_OUT
  } state_t;

  localparam logic [1:0] CFG_B0  = 2'd0;
  localparam logic [1:0] CFG_B1  = 2'd1;
  localparam logic [1:0] CFG_A1  = 2'd2;
  localparam logic [1:0] CFG_CLR = 2'd3;

  localparam logic [W_DEF-1:0] Q15_ONE = 16'h7FFF;

endpackage

// File: rtl/iir_mul_q15.sv
// Combinational signed fractional multiply: full product shifted right by W-1, low W bits kept.
module iir_mul_q15 #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_p
);

  logic signed [2*W-1:0] w_prod;

  assign w_prod = i_a * i_b;
  // Arithmetic shift then truncate: wraps rather than saturates on -1 * -1.
  assign o_p = W'(w_prod >>> (W-1));

endmodule

// File: rtl/iir_chan_sched.sv
// Per-channel first-order IIR sharing one Q1.15 multiplier: three multiplies per sample.
module iir_chan_sched
  import iir_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = W_DEF,
  parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [W-1:0]   out_data,
  input  logic           cfg_we,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [1:0]     cfg_sel,
  input  logic [W-1:0]   cfg_data
);

  localparam logic [W-1:0] ONE = (W == W_DEF) ? W'(Q15_ONE) : {1'b0, {(W-1){1'b1}}};

  state_t         r_state;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_acc;
  logic [CHW-1:0] r_ch;
  logic           r_out_valid;
  logic [CHW-1:0] r_out_ch;
  logic [W-1:0]   r_out_data;

  logic [W-1:0] r_b0 [NCH];
  logic [W-1:0] r_b1 [NCH];
  logic [W-1:0] r_a1 [NCH];
  logic [W-1:0] r_x1 [NCH];
  logic [W-1:0] r_y1 [NCH];

  logic           w_ch_ok;
  logic [CHW-1:0] w_idx;
  logic [W-1:0]   w_opa;
  logic [W-1:0]   w_opb;
  logic [W-1:0]   w_prod;
  logic           w_cfg_fire;
  logic           w_hist_fire;

  assign in_ready  = (r_state == S_IDLE) && !cfg_we;
  assign cfg_ready = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;

  // Out-of-range channels still run through the multiplier; they read channel 0 harmlessly.
  assign w_ch_ok     = (int'(r_ch) < NCH);
  assign w_idx       = w_ch_ok ? r_ch : '0;
  assign w_cfg_fire  = cfg_we && cfg_ready;
  assign w_hist_fire = (r_state == S_OUT) && out_ready;

  always_comb begin
    w_opa = r_b0[w_idx];
    w_opb = r_x;
    case (r_state)
      S_MB1: begin
        w_opa = r_b1[w_idx];
        w_opb = r_x1[w_idx];
      end
      S_MA1: begin
        w_opa = r_a1[w_idx];
        w_opb = r_y1[w_idx];
      end
      default: ;
    endcase
  end

  iir_mul_q15 #(.W(W)) u_mul (
    .i_a(w_opa),
    .i_b(w_opb),
    .o_p(w_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_acc       <= '0;
      r_ch        <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_x     <= in_data;
            r_ch    <= in_ch;
            r_acc   <= '0;
            r_state <= S_MB0;
          end
        end
        S_MB0: begin
          r_acc   <= w_prod;
          r_state <= S_MB1;
        end
        S_MB1: begin
          r_acc   <= r_acc + w_prod;
          r_state <= S_MA1;
        end
        S_MA1: begin
          r_acc <= r_acc - w_prod;
          if (w_ch_ok) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc - w_prod;
            r_out_ch    <= r_ch;
            r_state     <= S_OUT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Config only lands in IDLE and history only on output acceptance, so they never collide.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      always_ff @(posedge clk) begin
        if (reset) begin
          r_b0[gi] <= ONE;
          r_b1[gi] <= '0;
          r_a1[gi] <= '0;
          r_x1[gi] <= '0;
          r_y1[gi] <= '0;
        end else if (w_cfg_fire && (cfg_ch == CHW'(gi))) begin
          case (cfg_sel)
            CFG_B0: r_b0[gi] <= cfg_data;
            CFG_B1: r_b1[gi] <= cfg_data;
            CFG_A1: r_a1[gi] <= cfg_data;
            default: begin
              r_x1[gi] <= '0;
              r_y1[gi] <= '0;
            end
          endcase
        end else if (w_hist_fire && (r_ch == CHW'(gi))) begin
          r_x1[gi] <= r_x;
          r_y1[gi] <= r_acc;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_iir_chan_sched.sv
// Self-checking bench for iir_chan_sched: vector table plus hand-built corner sequences.
module tb_iir_chan_sched;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [CHW-1:0] in_ch;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [CHW-1:0] out_ch;
  logic [W-1:0]   out_data;
  logic           cfg_we;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [1:0]     cfg_sel;
  logic [W-1:0]   cfg_data;

  always #5 clk = ~clk;

  iir_chan_sched #(.NCH(NCH), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ch    (in_ch),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ch   (out_ch),
    .out_data (out_data),
    .cfg_we   (cfg_we),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data)
  );

  typedef struct {
    logic [CHW-1:0] ch;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
  } vec_t;

  typedef struct {
    logic [CHW-1:0] ch;
    logic [W-1:0]   data;
  } exp_t;

  exp_t sb[$];
  vec_t tv[9];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic do_cfg(input logic [CHW-1:0] ch, input logic [1:0] sel, input logic [W-1:0] d);
    int n = 0;
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = d;
    #1;
    while (!cfg_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    $display("cfg  ch=%0d sel=%0d data=0x%04h", ch, sel, d);
  endtask

  task automatic send(input logic [CHW-1:0] ch, input logic [W-1:0] x,
                      input bit push, input logic [W-1:0] y);
    int n = 0;
    exp_t e;
    in_valid = 1'b1; in_ch = ch; in_data = x;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      e.ch = ch; e.data = y;
      sb.push_back(e);
    end
  endtask

  task automatic recv(input bit chk_lat);
    int n = 0;
    exp_t e;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (chk_lat) check("latency", 32'(n), 32'd3);
    check("out_valid", 32'(out_valid), 32'd1);
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: output ch=%0d data=0x%04h with nothing expected", out_ch, out_data);
    end else begin
      e = sb.pop_front();
      check("out_ch", 32'(out_ch), 32'(e.ch));
      check("out_data", 32'(out_data), 32'(e.data));
      $display("txn  ch=%0d y=0x%04h expect=0x%04h", out_ch, out_data, e.data);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tv[0] = '{2'd0, 16'h1234, 16'h1233};
    tv[1] = '{2'd1, 16'h2000, 16'h1000};
    tv[2] = '{2'd1, 16'h2000, 16'h2000};
    tv[3] = '{2'd2, 16'h2000, 16'h1000};
    tv[4] = '{2'd3, 16'h4000, 16'h3FFF};
    tv[5] = '{2'd2, 16'h0000, 16'h0800};
    tv[6] = '{2'd3, 16'h4000, 16'h3FFF};
    tv[7] = '{2'd0, 16'h7FFF, 16'h7FFE};
    tv[8] = '{2'd0, 16'h7FFF, 16'hFFFC};

    reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    do_cfg(2'd1, 2'd0, 16'h4000);
    do_cfg(2'd1, 2'd1, 16'h4000);
    do_cfg(2'd2, 2'd0, 16'h4000);
    do_cfg(2'd2, 2'd2, 16'hC000);
    for (int i = 0; i < 7; i++) begin
      send(tv[i].ch, tv[i].x, 1'b1, tv[i].y);
      recv(i == 0);
    end

    // ch0 history is cleared so the wrap pair starts from x1=y1=0.
    do_cfg(2'd0, 2'd3, 16'h0000);
    do_cfg(2'd0, 2'd1, 16'h7FFF);
    for (int i = 7; i < 9; i++) begin
      send(tv[i].ch, tv[i].x, 1'b1, tv[i].y);
      recv(1'b0);
    end

    // Backpressure: result must hold for 10 cycles with out_ready low.
    send(2'd1, 16'h0000, 1'b1, 16'h1000);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    for (int k = 0; k < 10; k++) begin
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_out_data", 32'(out_data), 32'h1000);
      check("hold_out_ch", 32'(out_ch), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    recv(1'b0);

    // Config and sample offered together: config wins, sample follows next cycle.
    cfg_we = 1'b1; cfg_ch = 2'd3; cfg_sel = 2'd0; cfg_data = 16'h4000;
    in_valid = 1'b1; in_ch = 2'd3; in_data = 16'h4000;
    #1;
    check("both_in_ready", 32'(in_ready), 32'd0);
    check("both_cfg_ready", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    #1;
    check("after_cfg_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back('{2'd3, 16'h2000});
    recv(1'b1);

    // Reset while the sample sits in MB1.
    send(2'd1, 16'h2000, 1'b0, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("abort_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    do_cfg(2'd1, 2'd1, 16'h4000);
    send(2'd1, 16'h1234, 1'b1, 16'h1233);
    recv(1'b0);
    send(2'd2, 16'h2000, 1'b1, 16'h1FFF);
    recv(1'b0);

    // Clearing ch1 history must reproduce the no-history result.
    do_cfg(2'd1, 2'd3, 16'h0000);
    send(2'd1, 16'h1234, 1'b1, 16'h1233);
    recv(1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
